// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus consumer handshake and status flags of the UART receiver.
//   master modport (receiver): takes rxd and rx_ack; drives rxdata, rx_valid, rx_busy,
//                              rx_ferr, rx_ovr, rx_perr.
//   slave modport (line/consumer side): the mirror image.
interface uart_rx_if #(
  parameter int unsigned SIZE = 8
);
  logic            rxd;
  logic [SIZE-1:0] rxdata;
  logic            rx_valid;
  logic            rx_ack;
  logic            rx_busy;
  logic            rx_ferr;
  logic            rx_ovr;
  logic            rx_perr;

  modport master (
    input  rxd, rx_ack,
    output rxdata, rx_valid, rx_busy, rx_ferr, rx_ovr, rx_perr
  );

  modport slave (
    output rxd, rx_ack,
    input  rxdata, rx_valid, rx_busy, rx_ferr, rx_ovr, rx_perr
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: UART receiver. Oversamples rxd at CLKS_PER_BIT rxc cycles per bit, samples each
// bit at its midpoint and delivers SIZE-bit words (LSB first) over a level valid/ack handshake.
// Frame: start(0), SIZE data bits, [even parity], stop(1).
// Optional feature macro: UART_RX_PARITY_EN (adds the even-parity bit and rx_perr).
// Ports:
//   rxc    - receive clock, all state on rising edge
//   rst_n  - asynchronous active-low reset
//   rx     - uart_rx_if.master: rxd in, rx_ack in, rxdata/rx_valid/rx_busy/rx_ferr/rx_ovr/rx_perr out
module uart_rx #(
  parameter int unsigned SIZE         = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic      rxc,
  input  logic      rst_n,
  uart_rx_if.master rx
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(SIZE + 1);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             rxd_meta;
  logic             rxd_sync;
  logic             rxd_prev;

  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [SIZE-1:0]  shreg;

  logic [SIZE-1:0]  rxdata_q;
  logic             valid_q;
  logic             busy_q;
  logic             ferr_q;
  logic             ovr_q;

  logic             half_tick_c;
  logic             bit_tick_c;
  logic             counting_c;
  logic             shift_en_c;
  logic             done_c;
  logic             ferr_c;

`ifdef UART_RX_PARITY_EN
  logic             par_en_c;
  logic             par_bad;
  logic             perr_q;
`endif

  // Two-flop synchroniser plus one history flop for start-edge detection
  always_ff @(posedge rxc or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rx.rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign half_tick_c = (cnt == CNT_W'(HALF - 1));
  assign bit_tick_c  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign counting_c  = (state == S_START) || (state == S_DATA) ||
                       (state == S_PARITY) || (state == S_STOP);

  // State register
  always_ff @(posedge rxc or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-cycle strobes
  always_comb begin
    state_nxt  = state;
    shift_en_c = 1'b0;
    done_c     = 1'b0;
    ferr_c     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en_c   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (rxd_prev && !rxd_sync) state_nxt = S_START;
      end
      S_START: begin
        // A high line at mid-start is a glitch, not a frame
        if (half_tick_c) state_nxt = rxd_sync ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_tick_c) begin
          shift_en_c = 1'b1;
          if (bit_cnt == BIT_W'(SIZE - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_tick_c) begin
          par_en_c  = 1'b1;
          state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_tick_c) begin
          if (rxd_sync) begin
            done_c    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            ferr_c    = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Hold off until the line is released so a break is not read as a new start
        if (rxd_sync) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Divide and bit counters restart on every state entry; divide counter reloads per bit
  always_ff @(posedge rxc or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      if (state_nxt != state || bit_tick_c) cnt <= '0;
      else if (counting_c)                  cnt <= cnt + CNT_W'(1);

      if (state_nxt != state) bit_cnt <= '0;
      else if (shift_en_c)    bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  // Data shift register, LSB received first
  always_ff @(posedge rxc or negedge rst_n) begin
    if (!rst_n) shreg <= '0;
    else if (shift_en_c) shreg <= {rxd_sync, shreg[SIZE-1:1]};
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero
  always_ff @(posedge rxc or negedge rst_n) begin
    if (!rst_n) begin
      par_bad <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      if (par_en_c) par_bad <= (^shreg) ^ rxd_sync;
      perr_q <= done_c & par_bad;
    end
  end
  assign rx.rx_perr = perr_q;
`else
  assign rx.rx_perr = 1'b0;
`endif

  // Consumer handshake, overrun tracking and status outputs
  always_ff @(posedge rxc or negedge rst_n) begin
    if (!rst_n) begin
      rxdata_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      ferr_q <= ferr_c;
      busy_q <= (state_nxt != S_IDLE);
      if (done_c) begin
        if (!valid_q || rx.rx_ack) begin
          rxdata_q <= shreg;
          valid_q  <= 1'b1;
          if (rx.rx_ack) ovr_q <= 1'b0;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx.rx_ack) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign rx.rxdata   = rxdata_q;
  assign rx.rx_valid = valid_q;
  assign rx.rx_busy  = busy_q;
  assign rx.rx_ferr  = ferr_q;
  assign rx.rx_ovr   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomized frames against a handshake-level reference model.
module tb_uart_rx;

  localparam int unsigned SIZE = 8;
  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NBITS = SIZE + 3;
`else
  localparam int unsigned NBITS = SIZE + 2;
`endif
  // Negedge index within a frame at which the stop-bit midpoint sample is taken:
  // 2-cycle synchroniser delay plus half a bit into the stop bit
  localparam int unsigned STOP_CYC = (NBITS - 1) * CPB + 2 + HALF;

  logic rxc = 1'b0;
  logic rst_n;

  uart_rx_if #(.SIZE(SIZE)) rx_if ();

  uart_rx #(
    .SIZE(SIZE),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .rxc  (rxc),
    .rst_n(rst_n),
    .rx   (rx_if.master)
  );

  always #5 rxc = ~rxc;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [SIZE-1:0] m_data;
  logic            m_valid;
  logic            m_ovr;
  int              m_ferr;
  int              m_perr;

  // Pulse monitors
  int ferr_seen = 0;
  int perr_seen = 0;
  always @(posedge rxc) begin
    if (rx_if.rx_ferr === 1'b1) ferr_seen++;
    if (rx_if.rx_perr === 1'b1) perr_seen++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_data"},  32'(rx_if.rxdata),   32'(m_data));
    check({tag, "_valid"}, 32'(rx_if.rx_valid), 32'(m_valid));
    check({tag, "_ovr"},   32'(rx_if.rx_ovr),   32'(m_ovr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge rxc);
      rx_if.rxd    = 1'b1;
      rx_if.rx_ack = 1'b0;
    end
    check("idle_busy", 32'(rx_if.rx_busy), 32'd0);
  endtask

  task automatic ack_pulse();
    @(negedge rxc);
    rx_if.rx_ack = 1'b1;
    @(negedge rxc);
    rx_if.rx_ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    check_outputs("ack");
  endtask

  // One full frame; optionally raises rx_ack exactly in the stop-sample cycle
  task automatic send_frame(input logic [SIZE-1:0] d, input bit bad_stop,
                            input bit bad_par, input bit ack_at_stop);
    logic [NBITS-1:0] bits;
    bits       = '1;
    bits[0]    = 1'b0;
    bits[SIZE:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[SIZE+1] = (^d) ^ bad_par;
`endif
    bits[NBITS-1] = ~bad_stop;

    // Expected effect of this frame
    if (bad_stop) begin
      m_ferr++;
    end else begin
      if (!m_valid || ack_at_stop) begin
        m_data  = d;
        m_valid = 1'b1;
        if (ack_at_stop) m_ovr = 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      if (bad_par) m_perr++;
`endif
    end

    for (int c = 0; c < int'(NBITS * CPB); c++) begin
      @(negedge rxc);
      if (c == int'(STOP_CYC)) check("pre_stop_busy", 32'(rx_if.rx_busy), 32'd1);
      if (c == int'(STOP_CYC) + 1) begin
        check_outputs("frame");
        check("post_stop_busy", 32'(rx_if.rx_busy), 32'(bad_stop));
      end
      rx_if.rxd    = bits[c / int'(CPB)];
      rx_if.rx_ack = ack_at_stop && (c == int'(STOP_CYC));
    end
    @(negedge rxc);
    if (bad_stop) check("break_busy", 32'(rx_if.rx_busy), 32'd1);
    rx_if.rxd    = 1'b1;
    rx_if.rx_ack = 1'b0;
    check("ferr_count", 32'(ferr_seen), 32'(m_ferr));
    check("perr_count", 32'(perr_seen), 32'(m_perr));
  endtask

  initial begin
    logic [NBITS-1:0] fbits;
    logic [SIZE-1:0]  rd;
    bit               rbad, rpar, rack;

    rst_n        = 1'b0;
    rx_if.rxd    = 1'b1;
    rx_if.rx_ack = 1'b0;
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 0;
    m_perr  = 0;

    // Reset state
    repeat (3) @(negedge rxc);
    check_outputs("reset");
    check("reset_busy", 32'(rx_if.rx_busy), 32'd0);
    check("reset_ferr", 32'(rx_if.rx_ferr), 32'd0);
    check("reset_perr", 32'(rx_if.rx_perr), 32'd0);
    rst_n = 1'b1;
    idle(5);

    // 1: basic word then acknowledge
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    idle(5);
    ack_pulse();

    // 2: short start glitch is rejected, next frame still received
    for (int c = 0; c < 4; c++) begin
      @(negedge rxc);
      rx_if.rxd = 1'b0;
    end
    @(negedge rxc);
    check("glitch_busy_high", 32'(rx_if.rx_busy), 32'd1);
    rx_if.rxd = 1'b1;
    idle(20);
    check_outputs("glitch");
    check("glitch_ferr", 32'(ferr_seen), 32'(m_ferr));
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(5);
    ack_pulse();

    // 3: framing error
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    idle(6);
    check_outputs("ferr");

    // 4: overrun then acknowledge
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0);
    idle(6);
    send_frame(8'hCC, 1'b0, 1'b0, 1'b0);
    idle(6);
    check_outputs("ovr");
    ack_pulse();

    // 5: acknowledge coincident with completion
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0);
    idle(6);
    send_frame(8'hCC, 1'b0, 1'b0, 1'b1);
    idle(6);
    check_outputs("ack_coincident");
    ack_pulse();

`ifdef UART_RX_PARITY_EN
    // Parity mismatch still delivers the word
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    idle(6);
    ack_pulse();
`endif

    // 6: reset in the middle of a frame
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    idle(6);
    fbits = '1;
    fbits[0] = 1'b0;
    fbits[SIZE:1] = 8'hF0;
    for (int c = 0; c < int'(4 * CPB + HALF); c++) begin
      @(negedge rxc);
      rx_if.rxd = fbits[c / int'(CPB)];
    end
    @(negedge rxc);
    rst_n = 1'b0;
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    @(negedge rxc);
    check_outputs("midreset");
    check("midreset_busy", 32'(rx_if.rx_busy), 32'd0);
    check("midreset_ferr", 32'(rx_if.rx_ferr), 32'd0);
    rx_if.rxd = 1'b1;
    repeat (3) @(negedge rxc);
    rst_n = 1'b1;
    idle(6);
    check("midreset_ferr_count", 32'(ferr_seen), 32'(m_ferr));
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
    idle(5);
    ack_pulse();

    // Randomized frames
    for (int n = 0; n < 24; n++) begin
      rd   = SIZE'($urandom);
      rbad = ($urandom_range(0, 7) == 0);
      rpar = ($urandom_range(0, 3) == 0);
      rack = ($urandom_range(0, 3) == 0);
      send_frame(rd, rbad, rpar, rack);
      idle(int'($urandom_range(5, 12)));
      if ($urandom_range(0, 1) == 1) ack_pulse();
    end
    idle(5);
    check_outputs("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
